// File: rtl/d_ff_n.sv
// d_ff_n: N-bit parallel-in/parallel-out register with synchronous load enable.
//
// Each rising clk edge applies, in priority order:
//   res=1        -> Q <= RESET_VAL (en and D ignored)
//   res=0, en=1  -> Q <= D
//   res=0, en=0  -> Q holds
// Q comes straight from flops, so there is no combinational path from D to Q.
//
// Optional feature (macro D_FF_N_PARITY_EN):
//   When defined, an extra output q_par carries the even parity of Q. It is
//   kept in its own flop and updated on the same edge as Q, so it always
//   equals ^Q without an XOR tree on the output path. When undefined, the
//   port and its flop are absent and Q behaves the same.
//
// There is no handshake: the register captures on every enabled edge and
// never back-pressures. en is a plain level-sampled load strobe.
module d_ff_n #(
  parameter int           N         = 8,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         res,
  input  logic         en,
  input  logic [N-1:0] D,
`ifdef D_FF_N_PARITY_EN
  output logic [N-1:0] Q,
  output logic         q_par
`else
  output logic [N-1:0] Q
`endif
);

  // Stored word and its next value.
  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next-value select: load D when enabled, otherwise hold. Reset takes
  // priority and is applied in the register process below.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = D;
    end
  end

  // Data register: synchronous active-high reset, then the selected value.
  always_ff @(posedge clk) begin
    if (res) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

`ifdef D_FF_N_PARITY_EN
  // Parity of the stored word, tracked alongside it rather than recomputed
  // from Q, so q_par is also a pure flop output.
  logic par_q;
  logic par_d;

  // Next-parity select mirrors the data select: parity of D on load, hold
  // otherwise.
  always_comb begin
    par_d = par_q;
    if (en) begin
      par_d = ^D;
    end
  end

  // Parity register: reset value is the parity of RESET_VAL.
  always_ff @(posedge clk) begin
    if (res) begin
      par_q <= ^RESET_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_d_ff_n.sv
// tb_d_ff_n: bench for d_ff_n (N=8, RESET_VAL=0, 100 ps clock).
// Directed sequence with literal expectations, then randomized load/hold/reset
// traffic checked every cycle against a behavioural reference model.
`timescale 1ps/1ps
module tb_d_ff_n;
  localparam int           N  = 8;
  localparam logic [N-1:0] RV = '0;

  // ---------------- clock / reset block ----------------
  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         en  = 1'b0;
  logic [N-1:0] D   = '0;
  logic [N-1:0] Q;
`ifdef D_FF_N_PARITY_EN
  logic         q_par;
`endif

  always #50 clk = ~clk;

  d_ff_n #(.N(N), .RESET_VAL(RV)) dut (
    .clk  (clk),
    .res  (res),
    .en   (en),
    .D    (D),
`ifdef D_FF_N_PARITY_EN
    .Q    (Q),
    .q_par(q_par)
`else
    .Q    (Q)
`endif
  );

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The model holds "the word last written": reset writes RV, an enabled
  // edge writes D, anything else leaves it. Until the first write the value
  // is unknown and nothing is compared.
  logic [N-1:0] model_val   = '0;
  bit           model_known = 1'b0;
  logic [N-1:0] exp_q[$];

  always @(posedge clk) begin : model_blk
    logic [N-1:0] nxt;
    bit           nxt_known;
    nxt       = model_val;
    nxt_known = model_known;
    if (res === 1'b1) begin
      nxt       = RV;
      nxt_known = 1'b1;
    end else if (en === 1'b1) begin
      nxt       = D;
      nxt_known = 1'b1;
    end
    model_val   <= nxt;
    model_known <= nxt_known;
    if (nxt_known) exp_q.push_back(nxt);
  end

  // Compare process: sample 10 ps after each rising edge.
  always @(posedge clk) begin : cmp_blk
    logic [N-1:0] e;
    #10;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_q", Q, e);
`ifdef D_FF_N_PARITY_EN
      check("model_par", {{(N-1){1'b0}}, q_par}, {{(N-1){1'b0}}, ^e});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs at the falling edge, wait for the rising edge, then settle.
  task automatic drive(input logic r, input logic e, input logic [N-1:0] d);
    @(negedge clk);
    res = r;
    en  = e;
    D   = d;
    @(posedge clk);
    #20;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset over one edge
    drive(1'b1, 1'b0, 8'h00);
    check("reset_q", Q, 8'h00);
    // hold right after reset
    drive(1'b0, 1'b0, 8'hFF);
    check("hold_after_reset", Q, 8'h00);
    // 2. load AA
    drive(1'b0, 1'b1, 8'b10101010);
    check("load_aa", Q, 8'b10101010);
    // 3. en=0 holds
    drive(1'b0, 1'b0, 8'b01010101);
    check("hold_aa", Q, 8'b10101010);
    // 4. load 55
    drive(1'b0, 1'b1, 8'b01010101);
    check("load_55", Q, 8'b01010101);
    // 5. reset overrides en, then loading resumes
    drive(1'b0, 1'b1, 8'b10101010);
    check("reload_aa", Q, 8'b10101010);
    drive(1'b1, 1'b1, 8'b01010101);
    check("reset_over_en", Q, 8'h00);
    drive(1'b0, 1'b1, 8'b01010101);
    check("resume_55", Q, 8'b01010101);
    // 6. parity cases (Q checked in every build)
    drive(1'b0, 1'b1, 8'b00000111);
    check("load_07", Q, 8'h07);
`ifdef D_FF_N_PARITY_EN
    check("par_07", {7'b0, q_par}, 8'h01);
`endif
    drive(1'b0, 1'b1, 8'b00000011);
    check("load_03", Q, 8'h03);
`ifdef D_FF_N_PARITY_EN
    check("par_03", {7'b0, q_par}, 8'h00);
`endif
    drive(1'b1, 1'b0, 8'hFF);
    check("reset_again", Q, 8'h00);
`ifdef D_FF_N_PARITY_EN
    check("par_reset", {7'b0, q_par}, 8'h00);
`endif
    drive(1'b0, 1'b1, 8'hFF);
    check("load_ff", Q, 8'hFF);

    // Randomized traffic: D and en may change twice between edges; only the
    // values present at the rising edge should matter.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      res = ($urandom_range(0, 15) == 0);
      en  = $urandom_range(0, 1);
      D   = N'($urandom);
      #20;
      en  = $urandom_range(0, 1);
      D   = N'($urandom);
    end

    // Drain: a few quiet hold cycles so the last expectations are compared.
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
